traffic_scheduler: RTL and testbench

Game-flow and traffic-generation stage directly upstream of the car display. It runs the round state machine, paces obstacle movement from a programmable tick period, spawns one obstacle at a time in an LFSR-chosen lane, and scrolls it down the screen. It counts dodged obstacles and reacts to the collision flag. Its outputs drive the display's lane-select, obstacle Y, obstacle-active, game-active and game-over inputs.

---
 rtl/traffic_scheduler.sv | 179 +++++++++++++++++
 tb/tb_traffic_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_scheduler.sv
// traffic_scheduler: round state machine and obstacle generator feeding the car display.
// Paces obstacle movement from a programmable tick period, spawns one obstacle at a
// time in a pseudo-random lane, scrolls it down the screen, counts dodges, and
// reacts to the player collision flag.
//
// Optional feature macro: TRAFFIC_SPEEDUP_EN. When defined, the tick period halves
// every 8 points, up to 8x faster.
//
// Ports:
//   clk                 in   1   system/pixel clock, rising edge
//   rst                 in   1   asynchronous active-low reset
//   start               in   1   button level; only its rising edge is acted on
//   speed               in  20   tick period minus one, in clk cycles
//   rand_value          in  16   free-running LFSR value, sampled at spawn
//   collision           in   1   player/obstacle overlap flag
//   active_column       out  2   obstacle lane: 0 left, 1 middle, 2 right
//   traffic_y_position  out 10   top row of the obstacle
//   traffic_active      out  1   obstacle on screen
//   game_active         out  1   round in progress
//   game_over           out  1   crashed
//   score               out  8   dodged obstacles, saturating
module traffic_scheduler #(
    parameter int unsigned STEP_PX   = 4,
    parameter int unsigned Y_LIMIT   = 480,
    parameter int unsigned SPAWN_GAP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [19:0] speed,
    input  logic [15:0] rand_value,
    input  logic        collision,
    output logic [1:0]  active_column,
    output logic [9:0]  traffic_y_position,
    output logic        traffic_active,
    output logic        game_active,
    output logic        game_over,
    output logic [7:0]  score
);

    localparam int unsigned CNT_W = 20;
    localparam int unsigned Y_W   = 10;
    localparam int unsigned GAP_W = $clog2(SPAWN_GAP + 1);

    typedef enum logic [1:0] {IDLE, GAP, RUN, CRASH} state_t;

    state_t             state_q, state_n;
    logic               start_d, start_rise;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [GAP_W-1:0]   gap_q, gap_n;
    logic [1:0]         active_column_n;
    logic [Y_W-1:0]     traffic_y_position_n;
    logic               traffic_active_n;
    logic               game_active_n;
    logic               game_over_n;
    logic [7:0]         score_n;
    logic [CNT_W-1:0]   threshold_c;
    logic               running_c;
    logic               tick_c;
    logic               unused_c;

`ifdef TRAFFIC_SPEEDUP_EN
    logic [1:0]         level_q, level_n;
    assign threshold_c = speed >> level_q;
`else
    assign threshold_c = speed;
`endif

    // Only the lane bits of the LFSR matter here
    assign unused_c = ^rand_value[15:2];

    assign running_c = (state_q == GAP) || (state_q == RUN);
    assign tick_c    = running_c && (cnt_q >= threshold_c);

    // Next-state and next-output logic
    always_comb begin
        state_n              = state_q;
        cnt_n                = cnt_q;
        gap_n                = gap_q;
        active_column_n      = active_column;
        traffic_y_position_n = traffic_y_position;
        traffic_active_n     = traffic_active;
        score_n              = score;
`ifdef TRAFFIC_SPEEDUP_EN
        level_n              = level_q;
        // Level only changes at a tick so a period in progress is never cut short
        if (tick_c) begin
            level_n = (score[7:3] > 5'd3) ? 2'd3 : score[4:3];
        end
`endif
        if (tick_c) begin
            cnt_n = '0;
        end else if (running_c) begin
            cnt_n = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE, CRASH: begin
                if (start_rise) begin
                    score_n          = '0;
                    gap_n            = '0;
                    cnt_n            = '0;
                    traffic_active_n = 1'b0;
`ifdef TRAFFIC_SPEEDUP_EN
                    level_n          = '0;
`endif
                    state_n          = GAP;
                end
            end
            GAP: begin
                if (tick_c) begin
                    gap_n = gap_q + GAP_W'(1);
                    if (gap_q == GAP_W'(SPAWN_GAP - 1)) begin
                        // Lane 3 does not exist; fold it onto the middle lane
                        active_column_n      = (rand_value[1:0] == 2'd3) ? 2'd1 : rand_value[1:0];
                        traffic_y_position_n = '0;
                        traffic_active_n     = 1'b1;
                        state_n              = RUN;
                    end
                end
            end
            RUN: begin
                // Collision takes priority over a same-cycle despawn
                if (collision && traffic_active) begin
                    state_n = CRASH;
                end else if (tick_c) begin
                    if (traffic_y_position >= Y_W'(Y_LIMIT - STEP_PX)) begin
                        traffic_active_n = 1'b0;
                        score_n          = (score == 8'hFF) ? score : score + 8'd1;
                        gap_n            = '0;
                        state_n          = GAP;
                    end else begin
                        traffic_y_position_n = traffic_y_position + Y_W'(STEP_PX);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        game_active_n = (state_n == GAP) || (state_n == RUN);
        game_over_n   = (state_n == CRASH);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= IDLE;
            start_d            <= 1'b0;
            start_rise         <= 1'b0;
            cnt_q              <= '0;
            gap_q              <= '0;
            active_column      <= '0;
            traffic_y_position <= '0;
            traffic_active     <= 1'b0;
            game_active        <= 1'b0;
            game_over          <= 1'b0;
            score              <= '0;
`ifdef TRAFFIC_SPEEDUP_EN
            level_q            <= '0;
`endif
        end else begin
            state_q            <= state_n;
            start_d            <= start;
            start_rise         <= start & ~start_d;
            cnt_q              <= cnt_n;
            gap_q              <= gap_n;
            active_column      <= active_column_n;
            traffic_y_position <= traffic_y_position_n;
            traffic_active     <= traffic_active_n;
            game_active        <= game_active_n;
            game_over          <= game_over_n;
            score              <= score_n;
`ifdef TRAFFIC_SPEEDUP_EN
            level_q            <= level_n;
`endif
        end
    end

endmodule

// File: tb/tb_traffic_scheduler.sv
// Directed bench for traffic_scheduler: reset/idle, spawn, scroll/despawn, crash,
// restart, collision corner cases and asynchronous reset. Speedup pacing is
// exercised when TRAFFIC_SPEEDUP_EN is defined.
module tb_traffic_scheduler;

    logic        clk;
    logic        rst;
    logic        start;
    logic [19:0] speed;
    logic [15:0] rand_value;
    logic        collision;
    logic [1:0]  active_column;
    logic [9:0]  traffic_y_position;
    logic        traffic_active;
    logic        game_active;
    logic        game_over;
    logic [7:0]  score;

    int n_assert = 0;
    int n_fail   = 0;

    traffic_scheduler dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .speed              (speed),
        .rand_value         (rand_value),
        .collision          (collision),
        .active_column      (active_column),
        .traffic_y_position (traffic_y_position),
        .traffic_active     (traffic_active),
        .game_active        (game_active),
        .game_over          (game_over),
        .score              (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [22:0] outs();
        return {active_column, traffic_y_position, traffic_active, game_active, game_over, score};
    endfunction

`ifdef TRAFFIC_SPEEDUP_EN
    // Waits for score >= target within a cycle budget; returns 1 on success
    task automatic wait_score(input int target, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 60000; i++) begin
            @(negedge clk);
            if (int'(score) >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Measures cycles between two successive y moves of the next obstacle
    task automatic measure_period(output int p);
        logic [9:0] y0;
        p = -1;
        for (int i = 0; i < 5000 && !traffic_active; i++) @(negedge clk);
        y0 = traffic_y_position;
        for (int i = 0; i < 100 && traffic_y_position == y0; i++) @(negedge clk);
        y0 = traffic_y_position;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (traffic_y_position != y0) begin
                p = i;
                break;
            end
        end
    endtask
`endif

    initial begin
        logic [22:0] acc;
`ifdef TRAFFIC_SPEEDUP_EN
        logic ok;
        int   p;
`endif
        rst        = 1'b0;
        start      = 1'b0;
        speed      = 20'd3;
        rand_value = 16'hFFFF;
        collision  = 1'b0;

        // Reset and idle
        cyc(5);
        chk("reset_outputs", 32'(outs()), 32'd0);
        rst = 1'b1;
        acc = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            acc = acc | outs();
        end
        chk("idle_outputs", 32'(acc), 32'd0);

        // Start: game_active two cycles after the pin rises
        start = 1'b1;
        cyc(1);
        chk("start_lat1", 32'(game_active), 32'd0);
        cyc(1);
        chk("start_lat2", 32'(game_active), 32'd1);
        start = 1'b0;

        // Spawn 64 cycles after GAP entry, lane 3 folds to 1
        cyc(63);
        chk("pre_spawn", 32'(traffic_active), 32'd0);
        cyc(1);
        chk("spawn_active", 32'(traffic_active), 32'd1);
        chk("spawn_col", 32'(active_column), 32'd1);
        chk("spawn_y", 32'(traffic_y_position), 32'd0);

        // Scroll 4 px every 4 cycles
        cyc(3);
        chk("scroll_hold", 32'(traffic_y_position), 32'd0);
        cyc(1);
        chk("scroll_step", 32'(traffic_y_position), 32'd4);
        cyc(472);
        chk("scroll_last_y", 32'(traffic_y_position), 32'd476);
        cyc(3);
        chk("pre_despawn", 32'(traffic_active), 32'd1);
        cyc(1);
        chk("despawn_active", 32'(traffic_active), 32'd0);
        chk("despawn_score", 32'(score), 32'd1);
        chk("despawn_game", 32'(game_active), 32'd1);

        // Second spawn 64 cycles later, lane 2
        rand_value = 16'h1232;
        cyc(63);
        chk("gap2_empty", 32'(traffic_active), 32'd0);
        cyc(1);
        chk("spawn2_active", 32'(traffic_active), 32'd1);
        chk("spawn2_col", 32'(active_column), 32'd2);

        // Crash at y=200
        cyc(200);
        chk("crash_y_pre", 32'(traffic_y_position), 32'd200);
        collision = 1'b1;
        cyc(1);
        chk("crash_over", 32'(game_over), 32'd1);
        chk("crash_game", 32'(game_active), 32'd0);
        chk("crash_y", 32'(traffic_y_position), 32'd200);
        chk("crash_active", 32'(traffic_active), 32'd1);
        chk("crash_score", 32'(score), 32'd1);
        collision = 1'b0;
        cyc(10);
        chk("crash_hold", 32'(outs()), 32'({2'd2, 10'd200, 1'b1, 1'b0, 1'b1, 8'd1}));

        // Restart from CRASH
        start = 1'b1;
        cyc(1);
        chk("restart_lat1", 32'(game_over), 32'd1);
        cyc(1);
        chk("restart_over", 32'(game_over), 32'd0);
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_active", 32'(traffic_active), 32'd0);
        chk("restart_game", 32'(game_active), 32'd1);
        start = 1'b0;

        // Collision during GAP is ignored
        collision = 1'b1;
        cyc(5);
        chk("gap_coll_over", 32'(game_over), 32'd0);
        chk("gap_coll_game", 32'(game_active), 32'd1);
        collision = 1'b0;
        rand_value = 16'h0000;
        cyc(58);
        chk("gap3_empty", 32'(traffic_active), 32'd0);
        cyc(1);
        chk("spawn3_active", 32'(traffic_active), 32'd1);
        chk("spawn3_col", 32'(active_column), 32'd0);

        // Collision on the despawn tick: crash wins, no score
        cyc(479);
        chk("desp_coll_y", 32'(traffic_y_position), 32'd476);
        collision = 1'b1;
        cyc(1);
        chk("desp_coll_over", 32'(game_over), 32'd1);
        chk("desp_coll_score", 32'(score), 32'd0);
        chk("desp_coll_active", 32'(traffic_active), 32'd1);
        collision = 1'b0;

        // Async reset mid-RUN
        start = 1'b1;
        cyc(2);
        start = 1'b0;
        cyc(64);
        chk("spawn4_active", 32'(traffic_active), 32'd1);
        cyc(20);
        chk("run4_y", 32'(traffic_y_position), 32'd20);
        #2 rst = 1'b0;
        #1;
        chk("async_reset", 32'(outs()), 32'd0);
        cyc(3);
        rst = 1'b1;
        cyc(3);
        chk("post_reset_idle", 32'(outs()), 32'd0);

`ifdef TRAFFIC_SPEEDUP_EN
        speed = 20'd15;
        start = 1'b1;
        cyc(2);
        start = 1'b0;
        wait_score(8, ok);
        chk("wait_score8", 32'(ok), 32'd1);
        measure_period(p);
        chk("period_lvl1", 32'(p), 32'd8);
        wait_score(24, ok);
        chk("wait_score24", 32'(ok), 32'd1);
        measure_period(p);
        chk("period_lvl3", 32'(p), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
